period_meter: RTL and testbench

Measures the period of an asynchronous pulse/square input, counted in `clk` cycles; optional averaging over several periods. Receiving counterpart of the Measure-path strobe divider: it times edges that a divider (or an external comparator) produces. Results go to the measurement/reporting logic over a valid/ready handshake.

---
 rtl/measure_pkg.sv | 13 +
 rtl/edge_sync.sv | 27 ++
 rtl/period_meter.sv | 166 ++++++++++++++++
 tb/tb_period_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/measure_pkg.sv
// Shared types and defaults for the Measure-path blocks.
package measure_pkg;

  localparam int DEFAULT_CNT_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } meas_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level into clk and emits a one-cycle pulse on each rising edge.
// Every edge sees the same fixed latency, so interval measurements downstream are unaffected.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the interval between rising edges of sig_in in clk cycles.
// Define PERIOD_AVG_EN to report the average of 2^AVG_LOG2 consecutive periods instead of one.
module period_meter
  import measure_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT     = 50_000_000 - 1,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  meas_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] tcnt_reg, tcnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] cnt_inc, tcnt_inc;
  logic             busy_reg, valid_reg;
  logic             terr_reg, terr_next;
  logic             edge_pulse, timeout_hit;

`ifdef PERIOD_AVG_EN
  localparam int               ACC_W    = CNT_W + AVG_LOG2;
  localparam int               IDX_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_reg, acc_next, acc_sum;
  logic [IDX_W-1:0] idx_reg, idx_next;
`else
  logic unused_avg;
  assign unused_avg = ^AVG_LOG2;
`endif

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse)
  );

  // Both counters saturate so a runaway can never wrap into a small bogus value.
  assign cnt_inc     = (&cnt_reg)  ? cnt_reg  : cnt_reg  + CNT_ONE;
  assign tcnt_inc    = (&tcnt_reg) ? tcnt_reg : tcnt_reg + CNT_ONE;
  // >= rather than ==: an intermediate edge landing exactly on TIMEOUT must not skip the abort.
  assign timeout_hit = (tcnt_reg >= TIMEOUT_C);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    tcnt_next   = tcnt_reg;
    period_next = period_reg;
    terr_next   = 1'b0;
`ifdef PERIOD_AVG_EN
    acc_next = acc_reg;
    idx_next = idx_reg;
    acc_sum  = acc_reg + ACC_W'(cnt_reg);
`endif

    case (state_reg)
      IDLE: begin
        tcnt_next = '0;
        if (start) begin
          state_next = ARM;
        end
      end

      ARM: begin
        tcnt_next = tcnt_inc;
        if (edge_pulse) begin
          state_next = COUNT;
          cnt_next   = CNT_ONE;
`ifdef PERIOD_AVG_EN
          acc_next = '0;
          idx_next = '0;
`endif
        end else if (timeout_hit) begin
          state_next = IDLE;
          terr_next  = 1'b1;
        end
      end

      COUNT: begin
        tcnt_next = tcnt_inc;
        cnt_next  = cnt_inc;
        if (edge_pulse) begin
`ifdef PERIOD_AVG_EN
          if (idx_reg == IDX_LAST) begin
            period_next = CNT_W'(acc_sum >> AVG_LOG2);
            state_next  = DONE;
          end else begin
            acc_next = acc_sum;
            idx_next = idx_reg + IDX_W'(1);
            cnt_next = CNT_ONE;
          end
`else
          period_next = cnt_reg;
          state_next  = DONE;
`endif
        end else if (timeout_hit) begin
          state_next = IDLE;
          terr_next  = 1'b1;
        end
      end

      DONE: begin
        if (period_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      tcnt_reg   <= '0;
      period_reg <= '0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      terr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      tcnt_reg   <= tcnt_next;
      period_reg <= period_next;
      busy_reg   <= (state_next != IDLE);
      valid_reg  <= (state_next == DONE);
      terr_reg   <= terr_next;
    end
  end

`ifdef PERIOD_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      idx_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      idx_reg <= idx_next;
    end
  end
`endif

  assign busy         = busy_reg;
  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign timeout_err  = terr_reg;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus randomized edge trains,
// judged against an edge-time model (period = edge-time difference / number of periods).
module tb_period_meter;
  import measure_pkg::*;

  localparam int CNT_W    = 24;
  localparam int SYNC     = 2;
  localparam int AVG_LOG2 = 3;
`ifdef PERIOD_AVG_EN
  localparam int NPER   = 1 << AVG_LOG2;
  localparam int P_LONG = 300;
`else
  localparam int NPER   = 1;
  localparam int P_LONG = 2500;
`endif
  localparam int TO_A = NPER * P_LONG + 100;
  localparam int TO_B = 1000;

  logic clk = 1'b0;
  logic rst_n, sig_in, start, ready, sel;

  logic             start_a, start_b, ready_a, ready_b;
  logic             busy_a, busy_b, valid_a, valid_b, terr_a, terr_b;
  logic [CNT_W-1:0] period_a, period_b;

  logic             obs_busy, obs_valid, obs_terr;
  logic [CNT_W-1:0] obs_period;
  meas_state_t      obs_state;

  int n_assert = 0;
  int n_fail   = 0;
  int prev_period [2];
  int edge_q [$];
  int stray_q [$];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign ready_a = ready & ~sel;
  assign ready_b = ready & sel;

  assign obs_busy   = sel ? busy_b   : busy_a;
  assign obs_valid  = sel ? valid_b  : valid_a;
  assign obs_terr   = sel ? terr_b   : terr_a;
  assign obs_period = sel ? period_b : period_a;
  assign obs_state  = sel ? u_b.state_reg : u_a.state_reg;

  period_meter #(
    .CNT_W (CNT_W), .TIMEOUT (TO_A), .SYNC_STAGES (SYNC), .AVG_LOG2 (AVG_LOG2)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .sig_in (sig_in), .start (start_a), .busy (busy_a),
    .period (period_a), .period_valid (valid_a), .period_ready (ready_a),
    .timeout_err (terr_a)
  );

  period_meter #(
    .CNT_W (CNT_W), .TIMEOUT (TO_B), .SYNC_STAGES (SYNC), .AVG_LOG2 (AVG_LOG2)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .sig_in (sig_in), .start (start_b), .busy (busy_b),
    .period (period_b), .period_valid (valid_b), .period_ready (ready_b),
    .timeout_err (terr_b)
  );

  task automatic check(input string tag, input int it, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s iter %0d: observed %0d expected %0d", tag, it, obs, exp);
    end
  endtask

  function automatic bit has_val(input int q[$], input int v);
    foreach (q[k]) if (q[k] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Iteration i is sampled 1 time unit after clock edge i; start is driven at i=-1 and
  // accepted on edge 0. A sig_in rise driven at iteration a shows up as an edge whose
  // tcnt value is a+SYNC (tcnt counts from 0 in the first ARM cycle).
  task automatic run(input int s, input int delay, input int rst_at, input int n_rand,
                     input string tag);
    int tmo, tt, e_term, h, to_it, last, busy_last, newp, prevp;
    bit done;
    int ev [$];
    int strays [$];
    logic [31:0] exp_busy, exp_valid, exp_terr, exp_per;

    tmo = (s != 0) ? TO_B : TO_A;
    foreach (edge_q[k]) if (edge_q[k] + SYNC >= 0) ev.push_back(edge_q[k] + SYNC);
    // First cycle at/after TIMEOUT without an edge is where the measurement is abandoned.
    tt = tmo;
    while (has_val(ev, tt)) tt++;
    done   = (ev.size() > NPER) && (ev[NPER] < tt);
    prevp  = prev_period[s];
    e_term = done ? ev[NPER] : 0;
    newp   = done ? (ev[NPER] - ev[0]) / NPER : prevp;
    h      = e_term + 1 + delay;
    to_it  = tt + 1;
    last   = done ? h + 3 : to_it + 3;
    busy_last = done ? h : to_it - 1;
    strays = stray_q;
    for (int k = 0; k < n_rand; k++) strays.push_back(int'($urandom_range(0, busy_last)));
    sel = s[0];

    for (int i = -4; i <= last; i++) begin
      @(posedge clk);
      #1;
      exp_busy  = 32'((i >= 0) && (i <= busy_last));
      exp_valid = 32'(done && (i >= e_term + 1) && (i <= h));
      exp_terr  = 32'(!done && (i == to_it));
      exp_per   = (done && (i >= e_term + 1)) ? 32'(newp) : 32'(prevp);
      check({tag, "_busy"},   i, 32'(obs_busy),   exp_busy);
      check({tag, "_valid"},  i, 32'(obs_valid),  exp_valid);
      check({tag, "_terr"},   i, 32'(obs_terr),   exp_terr);
      check({tag, "_period"}, i, 32'(obs_period), exp_per);

      sig_in = has_val(edge_q, i);
      start  = (i == -1) || has_val(strays, i);
      ready  = done ? ((i == h) || ((i <= e_term) && (i % 5 == 2))) : (i % 5 == 2);

      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_busy"},   i, 32'(obs_busy),   32'd0);
        check({tag, "_rst_valid"},  i, 32'(obs_valid),  32'd0);
        check({tag, "_rst_terr"},   i, 32'(obs_terr),   32'd0);
        check({tag, "_rst_period"}, i, 32'(obs_period), 32'd0);
        check({tag, "_rst_state"},  i, 32'(obs_state),  32'(IDLE));
        prev_period[0] = 0;
        prev_period[1] = 0;
        #2;
        rst_n  = 1'b1;
        sig_in = 1'b0;
        start  = 1'b0;
        ready  = 1'b0;
        $display("run %-12s sel=%0d edges=%0d reset applied at iter %0d", tag, s,
                 edge_q.size(), i);
        return;
      end
    end
    sig_in = 1'b0;
    start  = 1'b0;
    ready  = 1'b0;
    if (done) prev_period[s] = newp;
    $display("run %-12s sel=%0d edges=%0d -> %s period=%0d", tag, s, edge_q.size(),
             done ? "result" : "timeout", newp);
  endtask

  task automatic chain(input int a0, input int p);
    edge_q.delete();
    for (int k = 0; k <= NPER; k++) edge_q.push_back(a0 + k * p);
  endtask

  initial begin
    int a;
    int nedge;
    rst_n = 1'b0;
    sig_in = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    sel = 1'b0;
    prev_period[0] = 0;
    prev_period[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("reset_busy",   -1, 32'(obs_busy),   32'd0);
      check("reset_valid",  -1, 32'(obs_valid),  32'd0);
      check("reset_terr",   -1, 32'(obs_terr),   32'd0);
      check("reset_period", -1, 32'(obs_period), 32'd0);
      check("reset_state",  -1, 32'(obs_state),  32'(IDLE));
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single long period, ready 10 cycles after valid.
    chain(20, P_LONG);
    run(0, 10, -1, 0, "t1_basic");

    // No edges at all: abandon after TIMEOUT+1 cycles, period untouched.
    edge_q.delete();
    run(1, 0, -1, 0, "t2_timeout");

    // Periods 100..107 (averaged build reports 103).
    edge_q.delete();
    a = 5;
    edge_q.push_back(a);
    for (int k = 0; k < 8; k++) begin
      a += 100 + k;
      edge_q.push_back(a);
    end
    run(0, 3, -1, 0, "t3_ramp");

    // Stray starts in COUNT and DONE, then a fresh run with an edge on the accepting cycle.
    chain(30, P_LONG);
    stray_q = '{30 + SYNC + 5, 30 + SYNC + NPER * P_LONG + 3};
    run(0, 10, -1, 0, "t4_strays");
    stray_q.delete();
    chain(10, P_LONG);
    edge_q.push_front(-3);
    run(0, 5, -1, 0, "t4_fresh");

    // Asynchronous reset mid-COUNT, then a clean measurement.
    chain(15, P_LONG);
    run(0, 0, 15 + SYNC + 50, 0, "t5_reset");
    repeat (3) @(posedge clk);
    run(0, 4, -1, 0, "t5_after");

    // Terminating edge exactly when tcnt == TIMEOUT, then one cycle too late.
    chain(TO_A - NPER * P_LONG - SYNC, P_LONG);
    run(0, 2, -1, 0, "t6_race");
    chain(TO_A - NPER * P_LONG - SYNC + 1, P_LONG);
    run(0, 2, -1, 0, "t6_late");

    for (int t = 0; t < 14; t++) begin
      edge_q.delete();
      a = int'($urandom_range(0, 950));
      nedge = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NPER)) : NPER + 1;
      for (int k = 0; k < nedge; k++) begin
        edge_q.push_back(a);
        a += int'($urandom_range(2, 120));
      end
      run(1, int'($urandom_range(0, 20)), -1, 1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
